// File: rtl/fetch_queue.sv
// Fetch-to-decode prefetch FIFO: first-word fall-through head, flush on taken
// branch, NOP (all-zero) head when empty.
module fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_instruction,
  input  logic [DATA_W-1:0] in_incremented_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instruction,
  output logic [DATA_W-1:0] out_incremented_pc,
  input  logic              flush,
  output logic [CNT_W-1:0]  count
);
  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } entry_t;

  entry_t [DEPTH-1:0] mem_q;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               push, pop;

  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign count     = count_q;

  assign out_instruction    = out_valid ? mem_q[rd_ptr_q].instr : '0;
  assign out_incremented_pc = out_valid ? mem_q[rd_ptr_q].pc    : '0;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      // Wrong-path entries, including any same-cycle push, are discarded.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      mem_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push && !flush) begin
        mem_q[wr_ptr_q].instr <= in_instruction;
        mem_q[wr_ptr_q].pc    <= in_incremented_pc;
      end
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a queue-based reference model checked every cycle.
module tb_fetch_queue;
  localparam int DEPTH = 4, DW = 32, CW = 3;

  logic          clk = 0, reset = 1, in_valid = 0, out_ready = 0, flush = 0;
  logic [DW-1:0] in_instruction = '0, in_incremented_pc = '0;
  logic          in_ready, out_valid;
  logic [DW-1:0] out_instruction, out_incremented_pc;
  logic [CW-1:0] count;

  fetch_queue #(.DEPTH(DEPTH), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instruction(in_instruction), .in_incremented_pc(in_incremented_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instruction(out_instruction),
    .out_incremented_pc(out_incremented_pc), .flush(flush), .count(count));

  always #5 clk = ~clk;

  typedef struct { logic [DW-1:0] instr; logic [DW-1:0] pc; } ent_t;
  ent_t mq[$];
  bit   started = 0;
  int   n_pass = 0, n_tot = 0;
  bit   seen_bad = 0;

  // Reference model: FIFO of paired entries, acting on the sampled inputs.
  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      started <= 1;
    end else if (flush) begin
      mq.delete();
    end else begin
      bit do_pop, do_push;
      do_pop  = out_ready && mq.size() > 0;
      do_push = in_valid && mq.size() < DEPTH;
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back('{in_instruction, in_incremented_pc});
    end
  end

  always @(negedge clk) begin
    if (started) begin
      logic [DW-1:0] ei, ep;
      int sz;
      sz = mq.size();
      ei = (sz > 0) ? mq[0].instr : '0;
      ep = (sz > 0) ? mq[0].pc : '0;
      n_tot++;
      if (count == CW'(sz) && out_valid == (sz != 0) && in_ready == (sz != DEPTH)) n_pass++;
      else $display("FAIL status: got count=%0d ov=%0b ir=%0b, want count=%0d ov=%0b ir=%0b",
                    count, out_valid, in_ready, sz, sz != 0, sz != DEPTH);
      n_tot++;
      if (out_instruction == ei && out_incremented_pc == ep) n_pass++;
      else $display("FAIL head: got instr=%h pc=%h, want instr=%h pc=%h",
                    out_instruction, out_incremented_pc, ei, ep);
      if (out_valid && (out_instruction == 32'hDEADBEEF || out_instruction == 32'hCAFEF00D ||
                        out_instruction == 32'h11111111))
        seen_bad = 1;
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  task automatic push1(input logic [DW-1:0] ins, input logic [DW-1:0] pc);
    in_valid = 1; in_instruction = ins; in_incremented_pc = pc;
    cyc();
    in_valid = 0;
  endtask

  logic [DW-1:0] tbl [4] = '{32'h8C010000, 32'h8C020004, 32'h00221820, 32'hAC030008};

  initial begin
    // 1. reset then idle
    cyc(2);
    reset = 0;
    chk("rst_count", DW'(count), 0);
    chk("rst_ov", DW'(out_valid), 0);
    chk("rst_ir", DW'(in_ready), 1);
    chk("rst_instr", out_instruction, 0);
    chk("rst_pc", out_incremented_pc, 0);
    cyc();

    // 2. fill then drain
    for (int i = 0; i < 4; i++) push1(tbl[i], DW'(4 * (i + 1)));
    chk("full_count", DW'(count), 4);
    chk("full_ir", DW'(in_ready), 0);
    push1(32'h11111111, 32'd20);
    chk("refused_count", DW'(count), 4);
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_instr", out_instruction, tbl[i]);
      chk("drain_pc", out_incremented_pc, DW'(4 * (i + 1)));
      chk("drain_count", DW'(count), DW'(4 - i));
      cyc();
    end
    chk("drained_ov", DW'(out_valid), 0);
    out_ready = 0;

    // 3. simultaneous push/pop across pointer wrap
    push1(32'hA0, 32'h100);
    push1(32'hA1, 32'h104);
    in_valid = 1; out_ready = 1;
    for (int i = 1; i <= 6; i++) begin
      in_instruction = DW'(i); in_incremented_pc = DW'(32'h200 + 4 * i);
      chk("pp_count", DW'(count), 2);
      chk("pp_head", out_instruction, (i == 1) ? 32'hA0 : (i == 2) ? 32'hA1 : DW'(i - 2));
      cyc();
    end
    in_valid = 0;
    chk("pp_tail5", out_instruction, 5);
    cyc();
    chk("pp_tail6", out_incremented_pc, 32'h218);
    cyc();
    out_ready = 0;

    // 4. flush mid-stream, then back-to-back flushes
    push1(32'h31, 4); push1(32'h32, 8); push1(32'h33, 12);
    chk("pre_flush_count", DW'(count), 3);
    flush = 1; in_valid = 1; in_instruction = 32'hDEADBEEF; in_incremented_pc = 32'h40;
    cyc();
    flush = 0; in_valid = 0;
    chk("flush_count", DW'(count), 0);
    chk("flush_ov", DW'(out_valid), 0);
    chk("flush_instr", out_instruction, 0);
    chk("flush_pc", out_incremented_pc, 0);
    push1(32'h12345678, 32'h44);
    chk("post_flush_instr", out_instruction, 32'h12345678);
    out_ready = 1; cyc(); out_ready = 0;
    flush = 1; cyc(2); flush = 0;
    push1(32'h55, 32'h58);
    chk("b2b_flush_push", out_instruction, 32'h55);
    out_ready = 1; cyc(); out_ready = 0;
    flush = 1; cyc(); flush = 0;
    chk("empty_flush_ir", DW'(in_ready), 1);

    // 5. full with pop: push refused
    for (int i = 1; i <= 4; i++) push1(DW'(32'h50 + i), DW'(4 * i));
    in_valid = 1; in_instruction = 32'hCAFEF00D; out_ready = 1;
    cyc();
    in_valid = 0;
    chk("fullpop_count", DW'(count), 3);
    chk("fullpop_head", out_instruction, 32'h52);
    cyc(4);
    chk("fullpop_empty", DW'(count), 0);
    out_ready = 0;

    // 6. reset over flush while pushing
    push1(32'h61, 4); push1(32'h62, 8); push1(32'h63, 12);
    reset = 1; flush = 1; in_valid = 1; in_instruction = 32'h77;
    cyc();
    reset = 0; flush = 0; in_valid = 0;
    chk("rf_count", DW'(count), 0);
    chk("rf_instr", out_instruction, 0);
    chk("rf_ir", DW'(in_ready), 1);
    out_ready = 1; cyc(3);
    chk("rf_still_empty", DW'(out_valid), 0);
    out_ready = 0;

    chk("wrong_path_seen", DW'(seen_bad), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
